ship_motion: RTL and testbench

Per-frame ship kinematics for the Arcade_template Asteroids core. Sits directly downstream of `sin_cos`: drives its `phase` input with the ship heading and consumes its signed Q1.17 `sin_val`/`cos_val` results. Once per `frame_tick` it updates heading, applies thrust along the heading, applies drag and advances a wrapping screen position. Results go to the renderer.

---
 rtl/ship_pkg.sv | 17 +
 rtl/wrap_add.sv | 29 ++
 rtl/ship_motion.sv | 141 ++++++++++++++
 tb/tb_ship_motion.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ship_pkg.sv
// Shared widths and FSM state encoding for the ship kinematics block.
package ship_pkg;
  localparam int PHASE_W  = 10;
  localparam int TRIG_W   = 18;
  localparam int VEL_W    = 16;
  localparam int POS_FRAC = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROTATE,
    S_WAIT1,
    S_WAIT2,
    S_VEL,
    S_DRAG,
    S_POS
  } state_t;
endpackage

// File: rtl/wrap_add.sv
// Adds a signed Q8.8 velocity to an unsigned Q.8 position, wrapping once modulo MAX<<8.
module wrap_add
  import ship_pkg::*;
#(
  parameter int MAX = 640,
  parameter int W   = 18
) (
  input  logic              [W-1:0]     p,
  input  logic signed       [VEL_W-1:0] v,
  output logic              [W-1:0]     q
);

  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] LIM = SW'(MAX << POS_FRAC);

  logic signed [SW-1:0] s;

  assign s = $signed({2'b00, p}) + SW'(v);

  // |v| is well below MAX<<8, so a single correction always lands in range
  always_comb begin
    q = s[W-1:0];
    if (s[SW-1])
      q = W'(s + LIM);
    else if (s >= LIM)
      q = W'(s - LIM);
  end

endmodule

// File: rtl/ship_motion.sv
// Per-frame ship update: heading, thrust along heading, drag, wrapping position.
// state    | meaning
// S_IDLE   | waiting for frame_tick, controls latched on tick
// S_ROTATE | heading/phase stepped
// S_WAIT1  | sin_cos pipeline stage 1
// S_WAIT2  | sin_cos pipeline stage 2
// S_VEL    | thrust added, saturated to +-VMAX
// S_DRAG   | velocity decays toward zero
// S_POS    | position advanced and wrapped, done pulsed
module ship_motion
  import ship_pkg::*;
#(
  parameter int X_MAX        = 640,
  parameter int Y_MAX        = 480,
  parameter int ROT_STEP     = 8,
  parameter int THRUST_SHIFT = 11,
  parameter int DRAG_SHIFT   = 6,
  parameter int VMAX         = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      rot_left,
  input  logic                      rot_right,
  input  logic                      thrust,
  output logic        [PHASE_W-1:0] phase,
  input  logic signed [TRIG_W-1:0]  sin_val,
  input  logic signed [TRIG_W-1:0]  cos_val,
  output logic        [PHASE_W-1:0] heading,
  output logic signed [VEL_W-1:0]   vel_x,
  output logic signed [VEL_W-1:0]   vel_y,
  output logic        [9:0]         pos_x,
  output logic        [8:0]         pos_y,
  output logic                      busy,
  output logic                      done
);

  localparam int XW = 18;
  localparam int YW = 17;
  localparam int SW = VEL_W + 1;
  localparam logic [XW-1:0] X_INIT = XW'((X_MAX / 2) << POS_FRAC);
  localparam logic [YW-1:0] Y_INIT = YW'((Y_MAX / 2) << POS_FRAC);
  localparam logic signed [SW-1:0] VMAX_S = SW'(VMAX);

  state_t state;
  logic lat_l, lat_r, lat_t;
  logic [XW-1:0] px, px_next;
  logic [YW-1:0] py, py_next;
  logic signed [TRIG_W-1:0] inc_x, inc_y;
  logic signed [SW-1:0] sum_x, sum_y;

  assign inc_x = cos_val >>> THRUST_SHIFT;
  assign inc_y = sin_val >>> THRUST_SHIFT;
  // screen y grows downward, so positive sin pushes vel_y negative
  assign sum_x = SW'(vel_x) + SW'(inc_x);
  assign sum_y = SW'(vel_y) - SW'(inc_y);

  assign heading = phase;
  assign pos_x   = px[XW-1:POS_FRAC];
  assign pos_y   = py[YW-1:POS_FRAC];

  function automatic logic signed [VEL_W-1:0] sat(input logic signed [SW-1:0] s);
    if (s > VMAX_S)
      return VEL_W'(VMAX_S);
    else if (s < -VMAX_S)
      return VEL_W'(-VMAX_S);
    else
      return VEL_W'(s);
  endfunction

  // Sign-magnitude decay so negative velocities truncate toward zero too
  function automatic logic signed [VEL_W-1:0] drag(input logic signed [VEL_W-1:0] v);
    logic [VEL_W-1:0] mag;
    logic [VEL_W-1:0] d;
    mag = v[VEL_W-1] ? VEL_W'(-v) : VEL_W'(v);
    d   = mag >> DRAG_SHIFT;
    return v[VEL_W-1] ? v + $signed(d) : v - $signed(d);
  endfunction

  wrap_add #(.MAX(X_MAX), .W(XW)) u_wrap_x (.p(px), .v(vel_x), .q(px_next));
  wrap_add #(.MAX(Y_MAX), .W(YW)) u_wrap_y (.p(py), .v(vel_y), .q(py_next));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      lat_l <= 1'b0;
      lat_r <= 1'b0;
      lat_t <= 1'b0;
      phase <= '0;
      vel_x <= '0;
      vel_y <= '0;
      px    <= X_INIT;
      py    <= Y_INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (frame_tick) begin
            lat_l <= rot_left;
            lat_r <= rot_right;
            lat_t <= thrust;
            busy  <= 1'b1;
            state <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          if (lat_l && !lat_r)
            phase <= phase + PHASE_W'(ROT_STEP);
          else if (lat_r && !lat_l)
            phase <= phase - PHASE_W'(ROT_STEP);
          state <= S_WAIT1;
        end
        S_WAIT1: state <= S_WAIT2;
        S_WAIT2: state <= S_VEL;
        S_VEL: begin
          if (lat_t) begin
            vel_x <= sat(sum_x);
            vel_y <= sat(sum_y);
          end
          state <= S_DRAG;
        end
        S_DRAG: begin
          vel_x <= drag(vel_x);
          vel_y <= drag(vel_y);
          state <= S_POS;
        end
        S_POS: begin
          px    <= px_next;
          py    <= py_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_motion.sv
// Directed-vector bench for ship_motion; trig inputs are driven directly by the bench.
module tb_ship_motion;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_tick = 1'b0;
  logic               rot_left = 1'b0;
  logic               rot_right = 1'b0;
  logic               thrust = 1'b0;
  logic        [9:0]  phase;
  logic signed [17:0] sin_val = '0;
  logic signed [17:0] cos_val = '0;
  logic        [9:0]  heading;
  logic signed [15:0] vel_x, vel_y;
  logic        [9:0]  pos_x;
  logic        [8:0]  pos_y;
  logic               busy, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ship_motion dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .rot_left(rot_left), .rot_right(rot_right), .thrust(thrust),
    .phase(phase), .sin_val(sin_val), .cos_val(cos_val),
    .heading(heading), .vel_x(vel_x), .vel_y(vel_y),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done)
  );

  typedef struct {
    bit          l, r, t;
    logic [17:0] s, c;
    int          h, vx, vy, px, py;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One frame: tick on edge E0, returns number of edges until done was seen (0 = timeout)
  task automatic do_frame(input bit l, input bit r, input bit t,
                          input logic [17:0] s, input logic [17:0] c, output int lat);
    @(negedge clk);
    rot_left = l; rot_right = r; thrust = t;
    sin_val = s; cos_val = c;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; rot_left = 1'b0; rot_right = 1'b0; thrust = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int prev_px;
    int over_cnt;
    bit wrap_seen;

    vecs[0]  = '{0, 0, 0, 18'h00000, 18'h00000,    0,   0,   0, 320, 240};
    vecs[1]  = '{0, 0, 1, 18'h00000, 18'h1FFFF,    0,  63,   0, 320, 240};
    vecs[2]  = '{0, 0, 1, 18'h00000, 18'h1FFFF,    0, 125,   0, 320, 240};
    vecs[3]  = '{0, 1, 0, 18'h00000, 18'h00000, 1016, 124,   0, 321, 240};
    vecs[4]  = '{1, 1, 0, 18'h00000, 18'h00000, 1016, 123,   0, 321, 240};
    vecs[5]  = '{1, 0, 0, 18'h00000, 18'h00000,    0, 122,   0, 322, 240};
    vecs[6]  = '{0, 0, 1, 18'h1FFFF, 18'h00000,    0, 121, -63, 322, 239};
    vecs[7]  = '{0, 0, 1, 18'h20001, 18'h00000,    0, 120,   1, 323, 239};
    vecs[8]  = '{0, 0, 1, 18'h00000, 18'h20001,    0,  56,   1, 323, 239};
    vecs[9]  = '{0, 0, 1, 18'h00000, 18'h20001,    0,  -8,   1, 323, 239};
    vecs[10] = '{0, 0, 1, 18'h00000, 18'h20000,    0, -71,   1, 323, 239};

    do_reset();
    repeat (3) @(negedge clk);
    chk("rst_heading", heading, 0);
    chk("rst_phase", phase, 0);
    chk("rst_vel_x", $signed(vel_x), 0);
    chk("rst_vel_y", $signed(vel_y), 0);
    chk("rst_pos_x", pos_x, 320);
    chk("rst_pos_y", pos_y, 240);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 11; i++) begin
      do_frame(vecs[i].l, vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].c, lat);
      chk($sformatf("v%0d_latency", i), lat, 6);
      chk($sformatf("v%0d_heading", i), heading, vecs[i].h);
      chk($sformatf("v%0d_vel_x", i), $signed(vel_x), vecs[i].vx);
      chk($sformatf("v%0d_vel_y", i), $signed(vel_y), vecs[i].vy);
      chk($sformatf("v%0d_pos_x", i), pos_x, vecs[i].px);
      chk($sformatf("v%0d_pos_y", i), pos_y, vecs[i].py);
    end

    // 32 left turns reach heading 256 (straight up), then thrust pushes vel_y negative
    do_reset();
    for (int i = 0; i < 32; i++) do_frame(1, 0, 0, 18'h0, 18'h0, lat);
    chk("rot32_heading", heading, 256);
    chk("rot32_phase", phase, 256);
    do_frame(0, 0, 1, 18'h1FFFF, 18'h00000, lat);
    chk("up_vel_y", $signed(vel_y), -63);
    chk("up_vel_x", $signed(vel_x), 0);

    // Sustained thrust: saturate, settle at 1008, wrap pos_x across the right edge
    do_reset();
    wrap_seen = 1'b0;
    over_cnt = 0;
    prev_px = pos_x;
    for (int i = 0; i < 100; i++) begin
      do_frame(0, 0, 1, 18'h00000, 18'h1FFFF, lat);
      if (pos_x >= 640) over_cnt++;
      if (prev_px >= 636 && pos_x < 4) wrap_seen = 1'b1;
      prev_px = pos_x;
    end
    chk("sat_vel_x", $signed(vel_x), 1008);
    chk("sat_vel_y", $signed(vel_y), 0);
    chk("wrap_seen", int'(wrap_seen), 1);
    chk("pos_x_ge_640_frames", over_cnt, 0);

    // A tick arriving while busy is dropped
    @(negedge clk);
    thrust = 1'b1; cos_val = 18'h1FFFF; sin_val = 18'h0;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; thrust = 1'b0;
    chk("busy_after_tick", busy, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("busy_tick_done_count", ndone, 1);
    chk("busy_idle_after", busy, 0);

    // Reset asserted in WAIT2 aborts the update
    @(negedge clk);
    rot_left = 1'b1; thrust = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; rot_left = 1'b0; thrust = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_heading", heading, 0);
    chk("abort_vel_x", $signed(vel_x), 0);
    chk("abort_vel_y", $signed(vel_y), 0);
    chk("abort_pos_x", pos_x, 320);
    chk("abort_pos_y", pos_y, 240);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_heading_after", heading, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
